// File: rtl/_ram8.sv
// Eight-word by WIDTH-bit RAM: per-word load decode on the write side and a
// three-level 2:1 mux tree on the read side. Reset clears every word asynchronously.
module _ram8 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic [2:0]       address,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] r_word [8];
  logic [7:0]       w_load;
  logic [WIDTH-1:0] w_lvl1 [4];
  logic [WIDTH-1:0] w_lvl2 [2];

  genvar k;
  generate
    for (k = 0; k < 8; k++) begin : g_word
      assign w_load[k] = load && (address == 3'(k));

      // Each bit either recirculates the stored value or takes new data.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_word[k] <= '0;
        end else begin
          r_word[k] <= w_load[k] ? in : r_word[k];
        end
      end
    end

    // Read tree: address[0] picks within pairs, then address[1], then address[2].
    for (k = 0; k < 4; k++) begin : g_lvl1
      assign w_lvl1[k] = address[0] ? r_word[2*k+1] : r_word[2*k];
    end
    for (k = 0; k < 2; k++) begin : g_lvl2
      assign w_lvl2[k] = address[1] ? w_lvl1[2*k+1] : w_lvl1[2*k];
    end
  endgenerate

  assign out = address[2] ? w_lvl2[1] : w_lvl2[0];

endmodule

// File: tb/tb__ram8.sv
// Bench for _ram8: an array model of the eight words, a per-cycle compare on
// the falling edge, hand-computed checks for the directed cases, then random traffic.
module tb__ram8;

  logic        clk;
  logic        rst_n;
  logic [15:0] in;
  logic        load;
  logic [2:0]  address;
  logic [15:0] out;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic        cmp_en  = 1'b0;
  logic [15:0] m_mem [8];

  _ram8 #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in      (in),
    .load    (load),
    .address (address),
    .out     (out)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: reset clears everything at once, otherwise the addressed
  // word takes the input at a rising edge when load is high.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) m_mem[i] = 16'h0000;
    end else if (load) begin
      m_mem[address] = in;
    end
  end

  task automatic chk(input string nm, input logic [15:0] exp);
    n_tests++;
    if (out !== exp) begin
      n_fail++;
      $display("FAIL %s: addr=%0d out=%h expected=%h at %0t", nm, address, out, exp, $time);
    end
  endtask

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (cmp_en) chk("model", m_mem[address]);
  end

  // Driver tasks: inputs always change 1 time unit after a rising edge.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    step();
    address = a;
    in      = d;
    load    = 1'b1;
    step();
    load    = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) m_mem[i] = 16'h0000;
    rst_n   = 1'b0;
    load    = 1'b0;
    in      = 16'h0000;
    address = 3'd0;
    #1;

    // Reset: all addresses read zero while reset is held
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      #1;
      chk("reset_read", 16'h0000);
    end

    step();
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // Write / readback
    for (int k = 0; k < 8; k++) wr(3'(k), 16'(16'h1111 * k + 16'h00A5));
    for (int k = 0; k < 8; k++) begin
      address = 3'(k);
      #1;
      chk("readback", 16'(16'h1111 * k + 16'h00A5));
    end

    // Hold
    step();
    load    = 1'b0;
    in      = 16'hFFFF;
    address = 3'd3;
    for (int e = 0; e < 4; e++) begin
      step();
      chk("hold", 16'h33D8);
    end

    // Read-during-write on the same address: old value until the edge
    wr(3'd5, 16'h5555);
    address = 3'd5;
    in      = 16'hBEEF;
    load    = 1'b1;
    #1;
    chk("rdw_before", 16'h5555);
    step();
    load = 1'b0;
    chk("rdw_after", 16'hBEEF);
    address = 3'd4;
    #1;
    chk("rdw_other", 16'h44E9);

    // Async reset overlapping a load cycle
    step();
    address = 3'd6;
    in      = 16'h1234;
    load    = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst", 16'h0000);
    load  = 1'b0;
    rst_n = 1'b1;
    step();
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      #1;
      chk("post_rst", 16'h0000);
    end

    // Edge only: input wiggles between edges must not matter
    for (int k = 0; k < 8; k++) wr(3'(k), 16'(16'h0101 * (k + 1)));
    step();
    load    = 1'b1;
    address = 3'd7; in = 16'hAAAA; #1;
    address = 3'd0; in = 16'h5555; #1;
    address = 3'd5; in = 16'h1357; #1;
    address = 3'd2; in = 16'h00FF;
    step();
    load = 1'b0;
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      #1;
      chk("edge_only", (a == 2) ? 16'h00FF : 16'(16'h0101 * (a + 1)));
    end

    // Random traffic with occasional short reset pulses
    for (int c = 0; c < 300; c++) begin
      step();
      address = 3'($urandom_range(0, 7));
      in      = 16'($urandom);
      load    = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 31) == 0) begin
        #1;
        rst_n = 1'b0;
        #1;
        chk("rand_rst", 16'h0000);
        rst_n = 1'b1;
      end
    end

    step();
    load = 1'b0;
    step();
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
